easy_fifo_axis_rr_arb: RTL

Round-robin AXI-Stream arbiter that shares one synchronous AXIS FIFO between NUM_SRC independent producers. It sits directly in front of the FIFO's slave port. It grants one source at a time for a bounded burst, tags every beat with its source index, and presents the merged stream through a single registered output stage. Fairness is guaranteed by a rotating priority pointer and a per-grant beat limit.

---
 rtl/easy_fifo_axis_rr_arb.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/easy_fifo_axis_rr_arb.sv
// Round-robin AXI-Stream arbiter feeding one shared FIFO slave port.
// One source is granted at a time for a bounded burst; every beat carries its source index.
module easy_fifo_axis_rr_arb #(
  parameter int NUM_SRC   = 4,
  parameter int DWIDTH    = 32,
  parameter int MAX_BURST = 8,
  localparam int IDW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*DWIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]        s_axis_tvalid,
  output logic [NUM_SRC-1:0]        s_axis_tready,
  output logic [DWIDTH-1:0]         m_axis_tdata,
  output logic [IDW-1:0]            m_axis_tid,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [NUM_SRC-1:0]        grant
);

  localparam int BCW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  state_t              r_state;
  logic [IDW-1:0]      r_ptr;
  logic [IDW-1:0]      r_gidx;
  logic [NUM_SRC-1:0]  r_grant;
  logic [BCW-1:0]      r_burst;
  logic                r_mvalid;
  logic [DWIDTH-1:0]   r_mdata;
  logic [IDW-1:0]      r_mid;

  logic                w_free;
  logic                w_gvalid;
  logic                w_accept;
  logic                w_limit;
  logic                w_release;
  logic                w_found;
  logic [IDW-1:0]      w_sel;
  logic [IDW:0]        w_sum;
  logic [IDW-1:0]      w_nextPtr;
  logic [DWIDTH-1:0]   w_gdata;

  assign w_free    = ~r_mvalid | m_axis_tready;
  assign w_gvalid  = |(s_axis_tvalid & r_grant);
  assign w_accept  = (r_state == ST_GRANT) & w_gvalid & w_free;
  assign w_limit   = (r_burst == BCW'(MAX_BURST - 1));
  assign w_release = (r_state == ST_GRANT) & (~w_gvalid | (w_accept & w_limit));
  assign w_nextPtr = (r_gidx == IDW'(NUM_SRC - 1)) ? '0 : r_gidx + IDW'(1);

  // Ready exists only during a grant, so IDLE always costs one dead cycle between grants.
  assign s_axis_tready = ((r_state == ST_GRANT) && w_free) ? r_grant : '0;

  assign grant         = r_grant;
  assign m_axis_tdata  = r_mdata;
  assign m_axis_tid    = r_mid;
  assign m_axis_tvalid = r_mvalid;

  // Rotating scan: first valid source at or after the priority pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(NUM_SRC)) begin
        w_sum = w_sum - (IDW+1)'(NUM_SRC);
      end
      if (!w_found && s_axis_tvalid[w_sum[IDW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    w_gdata = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_gidx == IDW'(i)) begin
        w_gdata = s_axis_tdata[i*DWIDTH +: DWIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_gidx  <= '0;
      r_grant <= '0;
      r_burst <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state <= ST_GRANT;
            r_gidx  <= w_sel;
            r_grant <= NUM_SRC'(1) << w_sel;
            r_burst <= '0;
          end
        end
        ST_GRANT: begin
          if (w_accept) begin
            r_burst <= r_burst + BCW'(1);
          end
          // The limit beat is still taken; a source dropping valid ends its grant even under backpressure.
          if (w_release) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_burst <= '0;
            r_ptr   <= w_nextPtr;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_burst <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mvalid <= 1'b0;
      r_mdata  <= '0;
      r_mid    <= '0;
    end else if (w_accept) begin
      r_mvalid <= 1'b1;
      r_mdata  <= w_gdata;
      r_mid    <= r_gidx;
    end else if (m_axis_tready) begin
      r_mvalid <= 1'b0;
    end
  end

endmodule
